// File: rtl/mux_lut_pipelined_if.sv
// Bus bundle for the pipelined LUT gate: evaluation request/result plus the
// serial truth-table configuration port. The master drives requests and
// table bits; the slave (the LUT) returns results and load status.
interface mux_lut_pipelined_if #(
    parameter int N = 2
);
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_data;
    logic         cfg_valid;
    logic         cfg_bit;
    logic         cfg_clear;
    logic         cfg_busy;
    logic         cfg_done;

    modport master (
        output in_valid, in_data, cfg_valid, cfg_bit, cfg_clear,
        input  out_valid, out_data, cfg_busy, cfg_done
    );

    modport slave (
        input  in_valid, in_data, cfg_valid, cfg_bit, cfg_clear,
        output out_valid, out_data, cfg_busy, cfg_done
    );
endinterface

// File: rtl/mux_lut_pipelined.sv
// N-input programmable lookup-table gate. The truth table is shifted in
// LSB-first into a shadow register and committed to the active table on the
// last bit. Evaluation runs through a 2:1 mux tree with one register stage
// per select bit, so a request sees the table of its acceptance cycle.
module mux_lut_pipelined #(
    parameter int                N    = 2,
    parameter logic [(1<<N)-1:0] INIT = 4'b1000
) (
    input  logic               clk,
    input  logic               rst,
    mux_lut_pipelined_if.slave bus
);
    localparam int T  = 1 << N;
    // Select bits still to be consumed travel alongside the data; stage k
    // carries N-1-k of them, packed back to back.
    localparam int SW = (N > 1) ? (N * (N - 1)) / 2 : 1;

    // Bit offset of stage k's mux outputs inside the packed value vector.
    function automatic int val_off(input int k);
        return T - (T >> k);
    endfunction

    // Bit offset of stage k's forwarded select bits.
    function automatic int sel_off(input int k);
        return k * (N - 1) - (k * (k - 1)) / 2;
    endfunction

    typedef enum logic {
        IDLE    = 1'b0,
        LOADING = 1'b1
    } state_t;

    state_t       state_reg, state_next;
    logic [N-1:0] cnt_reg, cnt_next;
    logic [T-1:0] act_reg, act_next;
    // The last table bit goes straight into the commit, so the shadow only
    // needs to hold entries 0..T-2.
    logic [T-2:0] shd_reg, shd_next;
    logic         done_reg, done_next;

    logic [T-2:0]  val_reg, val_next;
    logic [SW-1:0] sel_reg, sel_next;
    logic [N-1:0]  vld_reg, vld_next;

    // Load control: shift one bit per cfg_valid, commit the full table on
    // the last bit; clear abandons the partial load and drops its bit.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        act_next   = act_reg;
        shd_next   = shd_reg;
        done_next  = 1'b0;
        if (bus.cfg_clear) begin
            cnt_next = '0;
        end else if (bus.cfg_valid) begin
            cnt_next = cnt_reg + N'(1);
            if (cnt_reg == N'(T - 1)) begin
                act_next  = {bus.cfg_bit, shd_reg};
                done_next = 1'b1;
            end else begin
                shd_next[cnt_reg] = bus.cfg_bit;
            end
        end
        state_next = (cnt_next == '0) ? IDLE : LOADING;
    end

    // Load state, counter and tables; reset restores the power-up table.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            act_reg   <= INIT;
            shd_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            act_reg   <= act_next;
            shd_reg   <= shd_next;
            done_reg  <= done_next;
        end
    end

    // LOADING tracks cnt != 0 exactly, so busy follows the counter.
    assign bus.cfg_busy = (state_reg == LOADING);
    assign bus.cfg_done = done_reg;

    genvar gi, gj;

    // Mux tree: stage gi halves the candidate set using select bit gi.
    for (gi = 0; gi < N; gi++) begin : g_stage
        localparam int W  = T >> (gi + 1);
        localparam int VO = val_off(gi);

        logic [2*W-1:0] src;
        logic           sel;
        logic           vin;
        logic [W-1:0]   pick;

        if (gi == 0) begin : g_first
            assign src = act_reg;
            assign sel = bus.in_data[0];
            assign vin = bus.in_valid;
        end else begin : g_follow
            assign src = val_reg[val_off(gi - 1) +: 2*W];
            assign sel = sel_reg[sel_off(gi - 1)];
            assign vin = vld_reg[gi - 1];
        end

        for (gj = 0; gj < W; gj++) begin : g_mux
            assign pick[gj] = sel ? src[2*gj + 1] : src[2*gj];
        end

        assign vld_next[gi] = vin;

        if (gi == N - 1) begin : g_last
            // The final stage is the output register: it holds between
            // valid results.
            assign val_next[VO] = vin ? pick[0] : val_reg[VO];
        end else begin : g_mid
            localparam int SO = sel_off(gi);
            assign val_next[VO +: W] = pick;
            if (gi == 0) begin : g_sel_in
                assign sel_next[SO +: N-1] = bus.in_data[N-1:1];
            end else begin : g_sel_fwd
                assign sel_next[SO +: N-1-gi] = sel_reg[sel_off(gi - 1) + 1 +: N-1-gi];
            end
        end
    end

    if (N == 1) begin : g_no_sel
        assign sel_next = '0;
    end

    // Pipeline registers; reset drops every in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg <= '0;
            val_reg <= '0;
            sel_reg <= '0;
        end else begin
            vld_reg <= vld_next;
            val_reg <= val_next;
            sel_reg <= sel_next;
        end
    end

    assign bus.out_valid = vld_reg[N-1];
    assign bus.out_data  = val_reg[T-2];
endmodule

// File: tb/tb_mux_lut_pipelined.sv
// Bench for mux_lut_pipelined: an N=2 instance with the AND default table and
// an N=3 instance with the majority table. Expected results are queued with
// their due cycle when a request is driven and checked when out_valid rises.
module tb_mux_lut_pipelined;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_lut_pipelined_if #(.N(2)) bus2 ();
    mux_lut_pipelined_if #(.N(3)) bus3 ();

    mux_lut_pipelined #(.N(2), .INIT(4'b1000)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mux_lut_pipelined #(.N(3), .INIT(8'hE8))   dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        logic val;
        int   due;
    } exp_t;

    exp_t q2[$];
    exp_t q3[$];
    exp_t e2, e3;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference tables, shadow and bit count for each instance.
    logic [3:0] m_act2, m_shd2;
    logic [7:0] m_act3, m_shd3;
    int         m_cnt2, m_cnt3;
    bit         m_done2, m_done3;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every result must match the oldest request at its due cycle.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus2.out_valid === 1'b1) begin
                n_cmp++;
                if (q2.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb2_unexpected: out_data=%b at cycle %0d, required no result", bus2.out_data, cyc);
                end else begin
                    e2 = q2.pop_front();
                    if (bus2.out_data !== e2.val || cyc !== e2.due) begin
                        n_bad++;
                        $display("FAIL sb2_result: got %b at cycle %0d, required %b at cycle %0d", bus2.out_data, cyc, e2.val, e2.due);
                    end else
                        $display("n2 result %b at cycle %0d", bus2.out_data, cyc);
                end
            end
            if (bus3.out_valid === 1'b1) begin
                n_cmp++;
                if (q3.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb3_unexpected: out_data=%b at cycle %0d, required no result", bus3.out_data, cyc);
                end else begin
                    e3 = q3.pop_front();
                    if (bus3.out_data !== e3.val || cyc !== e3.due) begin
                        n_bad++;
                        $display("FAIL sb3_result: got %b at cycle %0d, required %b at cycle %0d", bus3.out_data, cyc, e3.val, e3.due);
                    end else
                        $display("n3 result %b at cycle %0d", bus3.out_data, cyc);
                end
            end
        end
    end

    task automatic idle();
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.cfg_valid = 1'b0; bus2.cfg_bit = 1'b0; bus2.cfg_clear = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.cfg_valid = 1'b0; bus3.cfg_bit = 1'b0; bus3.cfg_clear = 1'b0;
    endtask

    task automatic model_init();
        m_act2 = 4'b1000; m_shd2 = '0; m_cnt2 = 0; m_done2 = 0;
        m_act3 = 8'hE8;   m_shd3 = '0; m_cnt3 = 0; m_done3 = 0;
    endtask

    // One cycle: queue expectations from the table in force now, then apply
    // this cycle's config bit to the model, then advance to the next negedge.
    task automatic tick();
        exp_t e;
        m_done2 = 0;
        m_done3 = 0;
        if (bus2.in_valid) begin
            e.val = m_act2[bus2.in_data]; e.due = cyc + 2; q2.push_back(e);
        end
        if (bus3.in_valid) begin
            e.val = m_act3[bus3.in_data]; e.due = cyc + 3; q3.push_back(e);
        end
        if (bus2.cfg_clear) m_cnt2 = 0;
        else if (bus2.cfg_valid) begin
            m_shd2[m_cnt2] = bus2.cfg_bit;
            if (m_cnt2 == 3) begin m_act2 = m_shd2; m_cnt2 = 0; m_done2 = 1; end
            else m_cnt2++;
        end
        if (bus3.cfg_clear) m_cnt3 = 0;
        else if (bus3.cfg_valid) begin
            m_shd3[m_cnt3] = bus3.cfg_bit;
            if (m_cnt3 == 7) begin m_act3 = m_shd3; m_cnt3 = 0; m_done3 = 1; end
            else m_cnt3++;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic drain(input string tag);
        repeat (5) tick();
        n_cmp++;
        if (q2.size() != 0) begin n_bad++; $display("FAIL %s_drain2: %0d results outstanding, required 0", tag, q2.size()); end
        n_cmp++;
        if (q3.size() != 0) begin n_bad++; $display("FAIL %s_drain3: %0d results outstanding, required 0", tag, q3.size()); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        model_init();
        // Requests and config presented during reset must be ignored.
        bus2.in_valid = 1'b1; bus2.in_data = 2'd3; bus2.cfg_valid = 1'b1; bus2.cfg_bit = 1'b1;
        bus3.in_valid = 1'b1; bus3.in_data = 3'd7; bus3.cfg_valid = 1'b1; bus3.cfg_bit = 1'b1;
        repeat (3) @(negedge clk);
        idle();
        rst = 1'b0;
        n_cmp++; if (bus2.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid2: got %b, required 0", bus2.out_valid); end
        n_cmp++; if (bus2.out_data  !== 1'b0) begin n_bad++; $display("FAIL rst_out_data2: got %b, required 0", bus2.out_data); end
        n_cmp++; if (bus2.cfg_busy  !== 1'b0) begin n_bad++; $display("FAIL rst_busy2: got %b, required 0", bus2.cfg_busy); end
        n_cmp++; if (bus2.cfg_done  !== 1'b0) begin n_bad++; $display("FAIL rst_done2: got %b, required 0", bus2.cfg_done); end
        n_cmp++; if (bus3.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid3: got %b, required 0", bus3.out_valid); end
        n_cmp++; if (bus3.out_data  !== 1'b0) begin n_bad++; $display("FAIL rst_out_data3: got %b, required 0", bus3.out_data); end
        n_cmp++; if (bus3.cfg_busy  !== 1'b0) begin n_bad++; $display("FAIL rst_busy3: got %b, required 0", bus3.cfg_busy); end
        n_cmp++; if (bus3.cfg_done  !== 1'b0) begin n_bad++; $display("FAIL rst_done3: got %b, required 0", bus3.cfg_done); end
        tick();
        n_cmp++; if (bus2.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_post_valid2: got %b, required 0", bus2.out_valid); end
        n_cmp++; if (bus3.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_post_valid3: got %b, required 0", bus3.out_valid); end
        $display("test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_back_to_back_and();
        for (int d = 0; d < 4; d++) begin
            bus2.in_valid = 1'b1; bus2.in_data = 2'(d);
            tick();
        end
        drain("and");
        $display("test_back_to_back_and done at cycle %0d", cyc);
    endtask

    task automatic test_abort();
        logic [3:0] nand_tbl = 4'b0111;
        bus2.cfg_valid = 1'b1; bus2.cfg_bit = 1'b1; tick();
        bus2.cfg_valid = 1'b1; bus2.cfg_bit = 1'b1; tick();
        n_cmp++; if (bus2.cfg_busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_partial: got %b, required 1", bus2.cfg_busy); end
        bus2.cfg_valid = 1'b1; bus2.cfg_bit = 1'b1; bus2.cfg_clear = 1'b1; tick();
        n_cmp++; if (bus2.cfg_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_cleared: got %b, required 0", bus2.cfg_busy); end
        n_cmp++; if (bus2.cfg_done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b, required 0", bus2.cfg_done); end
        for (int d = 0; d < 4; d++) begin
            bus2.in_valid = 1'b1; bus2.in_data = 2'(d);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            bus2.cfg_valid = 1'b1; bus2.cfg_bit = nand_tbl[i];
            tick();
        end
        n_cmp++; if (bus2.cfg_done !== 1'b1) begin n_bad++; $display("FAIL abort_reload_done: got %b, required 1", bus2.cfg_done); end
        for (int d = 0; d < 4; d++) begin
            bus2.in_valid = 1'b1; bus2.in_data = 2'(d);
            tick();
        end
        drain("abort");
        $display("test_abort done at cycle %0d", cyc);
    endtask

    task automatic test_load_xor();
        logic [3:0] xor_tbl = 4'b0110;
        logic       want;
        for (int i = 0; i < 4; i++) begin
            bus2.cfg_valid = 1'b1; bus2.cfg_bit = xor_tbl[i];
            tick();
            want = (i < 3);
            n_cmp++; if (bus2.cfg_busy !== want) begin n_bad++; $display("FAIL xor_busy_%0d: got %b, required %b", i, bus2.cfg_busy, want); end
            want = (i == 3);
            n_cmp++; if (bus2.cfg_done !== want) begin n_bad++; $display("FAIL xor_done_%0d: got %b, required %b", i, bus2.cfg_done, want); end
        end
        tick();
        n_cmp++; if (bus2.cfg_done !== 1'b0) begin n_bad++; $display("FAIL xor_done_pulse: got %b, required 0", bus2.cfg_done); end
        n_cmp++; if (bus2.cfg_busy !== 1'b0) begin n_bad++; $display("FAIL xor_busy_after: got %b, required 0", bus2.cfg_busy); end
        for (int d = 0; d < 4; d++) begin
            bus2.in_valid = 1'b1; bus2.in_data = 2'(d);
            tick();
        end
        drain("xor");
        $display("test_load_xor done at cycle %0d", cyc);
    endtask

    task automatic test_commit_boundary();
        logic [3:0] and_tbl = 4'b1000;
        logic [3:0] or_tbl  = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            bus2.cfg_valid = 1'b1; bus2.cfg_bit = and_tbl[i];
            tick();
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            bus2.cfg_valid = 1'b1; bus2.cfg_bit = or_tbl[i];
            if (i == 3) begin bus2.in_valid = 1'b1; bus2.in_data = 2'd1; end
            tick();
        end
        bus2.in_valid = 1'b1; bus2.in_data = 2'd1;
        tick();
        drain("commit");
        $display("test_commit_boundary done at cycle %0d", cyc);
    endtask

    task automatic test_majority();
        for (int d = 0; d < 8; d++) begin
            bus3.in_valid = 1'b1; bus3.in_data = 3'(d);
            tick();
        end
        drain("majority");
        $display("test_majority done at cycle %0d", cyc);
    endtask

    task automatic test_random_loads();
        for (int n = 0; n < 300; n++) begin
            bus2.cfg_valid = ($urandom_range(0, 3) != 0); bus2.cfg_bit = 1'($urandom_range(0, 1));
            bus2.cfg_clear = ($urandom_range(0, 29) == 0);
            bus3.cfg_valid = ($urandom_range(0, 3) != 0); bus3.cfg_bit = 1'($urandom_range(0, 1));
            bus3.cfg_clear = ($urandom_range(0, 29) == 0);
            bus2.in_valid = ($urandom_range(0, 3) != 0); bus2.in_data = 2'($urandom_range(0, 3));
            bus3.in_valid = ($urandom_range(0, 3) != 0); bus3.in_data = 3'($urandom_range(0, 7));
            tick();
            n_cmp++; if (bus2.cfg_done !== m_done2) begin n_bad++; $display("FAIL rnd_done2: got %b, required %b", bus2.cfg_done, m_done2); end
            n_cmp++; if (bus2.cfg_busy !== (m_cnt2 != 0)) begin n_bad++; $display("FAIL rnd_busy2: got %b, required %b", bus2.cfg_busy, (m_cnt2 != 0)); end
            n_cmp++; if (bus3.cfg_done !== m_done3) begin n_bad++; $display("FAIL rnd_done3: got %b, required %b", bus3.cfg_done, m_done3); end
            n_cmp++; if (bus3.cfg_busy !== (m_cnt3 != 0)) begin n_bad++; $display("FAIL rnd_busy3: got %b, required %b", bus3.cfg_busy, (m_cnt3 != 0)); end
        end
        bus2.cfg_clear = 1'b1; bus3.cfg_clear = 1'b1;
        tick();
        drain("random");
        $display("test_random_loads done at cycle %0d", cyc);
    endtask

    task automatic test_reset_mid();
        bus2.cfg_valid = 1'b1; bus2.cfg_bit = 1'b1; bus2.in_valid = 1'b1; bus2.in_data = 2'd3;
        bus3.in_valid = 1'b1; bus3.in_data = 3'd7;
        tick();
        bus2.cfg_valid = 1'b1; bus2.cfg_bit = 1'b0; bus2.in_valid = 1'b1; bus2.in_data = 2'd2;
        bus3.in_valid = 1'b1; bus3.in_data = 3'd6;
        tick();
        n_cmp++; if (bus2.cfg_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b, required 1", bus2.cfg_busy); end
        bus2.in_valid = 1'b1; bus2.in_data = 2'd1;
        bus3.in_valid = 1'b1; bus3.in_data = 3'd5;
        rst = 1'b1;
        @(negedge clk);
        idle();
        rst = 1'b0;
        q2.delete();
        q3.delete();
        model_init();
        n_cmp++; if (bus2.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid2: got %b, required 0", bus2.out_valid); end
        n_cmp++; if (bus3.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid3: got %b, required 0", bus3.out_valid); end
        n_cmp++; if (bus2.cfg_busy  !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b, required 0", bus2.cfg_busy); end
        n_cmp++; if (bus2.out_data  !== 1'b0) begin n_bad++; $display("FAIL rstmid_data2: got %b, required 0", bus2.out_data); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (bus2.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_flush2_%0d: got %b, required 0", k, bus2.out_valid); end
            n_cmp++; if (bus3.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_flush3_%0d: got %b, required 0", k, bus3.out_valid); end
            n_cmp++; if (bus2.cfg_done  !== 1'b0) begin n_bad++; $display("FAIL rstmid_done_%0d: got %b, required 0", k, bus2.cfg_done); end
        end
        for (int d = 0; d < 8; d++) begin
            bus2.in_valid = 1'b1; bus2.in_data = 2'(d % 4);
            bus3.in_valid = 1'b1; bus3.in_data = 3'(d);
            tick();
        end
        drain("rstmid");
        $display("test_reset_mid done at cycle %0d", cyc);
    endtask

    initial begin
        test_reset();
        test_back_to_back_and();
        test_abort();
        test_load_xor();
        test_commit_boundary();
        test_majority();
        test_random_loads();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
